// File: rtl/switch_event_arbiter_pkg.sv
// Shared encodings for the switch event arbiter: event kinds, repeat-timer phases
// and the round-robin index wrap helper.
package switch_event_arbiter_pkg;

    localparam logic EVT_PRESS  = 1'b0;
    localparam logic EVT_REPEAT = 1'b1;

    typedef enum logic [1:0] {
        PH_IDLE   = 2'd0,
        PH_DELAY  = 2'd1,
        PH_PERIOD = 2'd2
    } phase_t;

    // Wraps an index that may run at most one lap past num back into 0..num-1.
    function automatic int rr_wrap(input int idx, input int num);
        return (idx >= num) ? idx - num : idx;
    endfunction

endpackage

// File: rtl/switch_event_arbiter_timer.sv
// Per-switch auto-repeat timer: measures hold time and emits a one-cycle repeat tick.
//   state     | meaning
//   PH_IDLE   | switch released or repeat disabled, counter held at 0
//   PH_DELAY  | waiting REPEAT_DELAY cycles after the press for the first repeat
//   PH_PERIOD | waiting REPEAT_PERIOD cycles between later repeats
module switch_event_arbiter_timer
    import switch_event_arbiter_pkg::*;
#(
    parameter int REPEAT_DELAY  = 12500000,
    parameter int REPEAT_PERIOD = 2500000,
    parameter int CNT_W         = 24
) (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    input  logic rise,
    input  logic enable,
    output logic repeat_tick
);

    phase_t           phase;
    logic [CNT_W-1:0] count;
    logic             limit_hit;

    always_comb begin
        limit_hit = 1'b0;
        case (phase)
            PH_DELAY:  limit_hit = (count == CNT_W'(REPEAT_DELAY - 1));
            PH_PERIOD: limit_hit = (count == CNT_W'(REPEAT_PERIOD - 1));
            default:   limit_hit = 1'b0;
        endcase
    end

    // A fresh press restarts the delay, so it must never coincide with a tick.
    assign repeat_tick = level & enable & ~rise & limit_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= PH_IDLE;
            count <= '0;
        end else if (!level || !enable) begin
            phase <= PH_IDLE;
            count <= '0;
        end else if (rise) begin
            phase <= PH_DELAY;
            count <= '0;
        end else if (limit_hit) begin
            phase <= PH_PERIOD;
            count <= '0;
        end else if (phase != PH_IDLE) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/switch_event_arbiter.sv
// Converts debounced switch levels into press/auto-repeat events, one pending slot per
// switch, shared onto a single valid/ready event port by round-robin arbitration.
module switch_event_arbiter
    import switch_event_arbiter_pkg::*;
#(
    parameter int NUM_SW        = 4,
    parameter int ID_W          = 2,
    parameter int REPEAT_DELAY  = 12500000,
    parameter int REPEAT_PERIOD = 2500000,
    parameter int CNT_W         = 24
) (
    input  logic              i_Clk,
    input  logic              i_Rst_L,
    input  logic [NUM_SW-1:0] i_Switch,
    input  logic              i_Repeat_En,
    output logic              o_Event_Valid,
    input  logic              i_Event_Ready,
    output logic [ID_W-1:0]   o_Event_Id,
    output logic              o_Event_Repeat,
    output logic [NUM_SW-1:0] o_Pending,
    output logic              o_Overflow
);

    logic [NUM_SW-1:0] sw_q;
    logic [NUM_SW-1:0] rise;
    logic [NUM_SW-1:0] tick;
    logic [NUM_SW-1:0] new_evt;
    logic [NUM_SW-1:0] pending;
    logic [NUM_SW-1:0] rflag;
    logic [NUM_SW-1:0] grant_mask;
    logic [NUM_SW-1:0] pending_nxt;
    logic [NUM_SW-1:0] rflag_nxt;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   grant_idx;
    logic              grant_any;
    logic              slot_free;
    logic              overflow_nxt;

    assign rise      = i_Switch & ~sw_q;
    assign new_evt   = rise | tick;
    assign slot_free = ~o_Event_Valid | i_Event_Ready;
    assign o_Pending = pending;

    for (genvar k = 0; k < NUM_SW; k++) begin : g_timer
        switch_event_arbiter_timer #(
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD),
            .CNT_W        (CNT_W)
        ) u_timer (
            .clk        (i_Clk),
            .rst_n      (i_Rst_L),
            .level      (i_Switch[k]),
            .rise       (rise[k]),
            .enable     (i_Repeat_En),
            .repeat_tick(tick[k])
        );
    end

    // First pending channel at or after the pointer, only when the output slot can take it.
    always_comb begin
        int idx;
        idx        = 0;
        grant_any  = 1'b0;
        grant_idx  = '0;
        grant_mask = '0;
        if (slot_free) begin
            for (int i = 0; i < NUM_SW; i++) begin
                idx = rr_wrap(int'(ptr) + i, NUM_SW);
                if (!grant_any && pending[idx]) begin
                    grant_any = 1'b1;
                    grant_idx = ID_W'(idx);
                end
            end
        end
        if (grant_any) grant_mask[grant_idx] = 1'b1;
    end

    // A new event on a channel being granted this cycle simply re-arms its slot.
    always_comb begin
        pending_nxt  = pending & ~grant_mask;
        rflag_nxt    = rflag;
        overflow_nxt = |(new_evt & pending & ~grant_mask);
        for (int k = 0; k < NUM_SW; k++) begin
            if (new_evt[k]) begin
                pending_nxt[k] = 1'b1;
                rflag_nxt[k]   = rise[k] ? EVT_PRESS : EVT_REPEAT;
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sw_q           <= '0;
            pending        <= '0;
            rflag          <= '0;
            ptr            <= '0;
            o_Event_Valid  <= 1'b0;
            o_Event_Id     <= '0;
            o_Event_Repeat <= 1'b0;
            o_Overflow     <= 1'b0;
        end else begin
            sw_q       <= i_Switch;
            pending    <= pending_nxt;
            rflag      <= rflag_nxt;
            o_Overflow <= overflow_nxt;
            if (slot_free) begin
                o_Event_Valid <= grant_any;
                if (grant_any) begin
                    o_Event_Id     <= grant_idx;
                    o_Event_Repeat <= rflag[grant_idx];
                    ptr            <= ID_W'(rr_wrap(int'(grant_idx) + 1, NUM_SW));
                end
            end
        end
    end

endmodule

// File: tb/tb_switch_event_arbiter.sv
// Self-checking bench for switch_event_arbiter: cycle vectors plus an event scoreboard.
module tb_switch_event_arbiter;

    localparam int NV = 40;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] sw = 4'b0000;
    logic       rep_en = 1'b0;
    logic       ready = 1'b1;
    logic       valid;
    logic [1:0] id;
    logic       rep;
    logic [3:0] pending;
    logic       ovf;

    int tests = 0;
    int failed = 0;
    int ovf_cnt = 0;

    typedef struct packed {
        logic [1:0] id;
        logic       rep;
    } evt_t;

    typedef struct packed {
        logic       rst;
        logic [3:0] sw;
        logic       rdy;
        logic [1:0] npush;
        logic [5:0] pids;
        logic       e_valid;
        logic [1:0] e_id;
        logic [3:0] e_pend;
        logic       e_ovf;
    } vec_t;

    evt_t sb_q[$];
    evt_t mon_e;
    vec_t vecs[NV];

    always #5 clk = ~clk;

    switch_event_arbiter #(
        .NUM_SW(4), .ID_W(2), .REPEAT_DELAY(8), .REPEAT_PERIOD(4), .CNT_W(24)
    ) dut (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_Switch(sw), .i_Repeat_En(rep_en),
        .o_Event_Valid(valid), .i_Event_Ready(ready), .o_Event_Id(id),
        .o_Event_Repeat(rep), .o_Pending(pending), .o_Overflow(ovf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [1:0] pid, input logic prep);
        evt_t e;
        e.id  = pid;
        e.rep = prep;
        sb_q.push_back(e);
    endtask

    function automatic vec_t mk(input logic r, input logic [3:0] s, input logic rd,
                                input logic [1:0] np, input logic [5:0] pid, input logic ev,
                                input logic [1:0] eid, input logic [3:0] ep, input logic eo);
        vec_t v;
        v.rst = r; v.sw = s; v.rdy = rd; v.npush = np; v.pids = pid;
        v.e_valid = ev; v.e_id = eid; v.e_pend = ep; v.e_ovf = eo;
        return v;
    endfunction

    // Scoreboard: every accepted handshake must match the oldest expected event.
    always @(negedge clk) begin
        if (rst_n && ovf) ovf_cnt++;
        if (rst_n && valid && ready) begin
            tests++;
            if (sb_q.size() == 0) begin
                failed++;
                $display("FAIL sb_unexpected actual id=%0d rep=%0d required=no event", id, rep);
            end else begin
                mon_e = sb_q.pop_front();
                if ({id, rep} !== {mon_e.id, mon_e.rep}) begin
                    failed++;
                    $display("FAIL sb_event actual id=%0d rep=%0d required id=%0d rep=%0d",
                             id, rep, mon_e.id, mon_e.rep);
                end
            end
        end
    end

    initial begin
        vec_t v;
        //              rst sw     rdy np pids        ev id ep     ov
        vecs[0]  = mk(0, 4'b0000, 1, 0, 6'd0,        0, 0, 4'b0000, 0);
        vecs[1]  = mk(1, 4'b0000, 1, 0, 6'd0,        0, 0, 4'b0000, 0);
        vecs[2]  = mk(1, 4'b0100, 1, 1, 6'd2,        0, 0, 4'b0100, 0);
        vecs[3]  = mk(1, 4'b0100, 1, 0, 6'd0,        1, 2, 4'b0000, 0);
        vecs[4]  = mk(1, 4'b0100, 1, 0, 6'd0,        0, 0, 4'b0000, 0);
        vecs[5]  = mk(1, 4'b0000, 1, 0, 6'd0,        0, 0, 4'b0000, 0);
        vecs[6]  = mk(0, 4'b0000, 1, 0, 6'd0,        0, 0, 4'b0000, 0);
        vecs[7]  = mk(1, 4'b0000, 1, 0, 6'd0,        0, 0, 4'b0000, 0);
        vecs[8]  = mk(1, 4'b1011, 1, 3, 6'b110100,   0, 0, 4'b1011, 0);
        vecs[9]  = mk(1, 4'b1011, 1, 0, 6'd0,        1, 0, 4'b1010, 0);
        vecs[10] = mk(1, 4'b1011, 1, 0, 6'd0,        1, 1, 4'b1000, 0);
        vecs[11] = mk(1, 4'b0000, 1, 0, 6'd0,        1, 3, 4'b0000, 0);
        vecs[12] = mk(1, 4'b1001, 1, 2, 6'b001100,   0, 0, 4'b1001, 0);
        vecs[13] = mk(1, 4'b0000, 1, 0, 6'd0,        1, 0, 4'b1000, 0);
        vecs[14] = mk(1, 4'b0000, 1, 0, 6'd0,        1, 3, 4'b0000, 0);
        vecs[15] = mk(1, 4'b0000, 1, 0, 6'd0,        0, 0, 4'b0000, 0);
        vecs[16] = mk(1, 4'b0010, 1, 1, 6'd1,        0, 0, 4'b0010, 0);
        vecs[17] = mk(1, 4'b0000, 1, 0, 6'd0,        1, 1, 4'b0000, 0);
        vecs[18] = mk(1, 4'b0101, 1, 2, 6'b000010,   0, 0, 4'b0101, 0);
        vecs[19] = mk(1, 4'b0000, 1, 0, 6'd0,        1, 2, 4'b0001, 0);
        vecs[20] = mk(1, 4'b0000, 1, 0, 6'd0,        1, 0, 4'b0000, 0);
        vecs[21] = mk(1, 4'b0000, 1, 0, 6'd0,        0, 0, 4'b0000, 0);
        vecs[22] = mk(1, 4'b0010, 0, 1, 6'd1,        0, 0, 4'b0010, 0);
        vecs[23] = mk(1, 4'b0010, 0, 0, 6'd0,        1, 1, 4'b0000, 0);
        vecs[24] = mk(1, 4'b0000, 0, 0, 6'd0,        1, 1, 4'b0000, 0);
        vecs[25] = mk(1, 4'b0010, 0, 1, 6'd1,        1, 1, 4'b0010, 0);
        vecs[26] = mk(1, 4'b0000, 0, 0, 6'd0,        1, 1, 4'b0010, 0);
        vecs[27] = mk(1, 4'b0010, 0, 0, 6'd0,        1, 1, 4'b0010, 1);
        vecs[28] = mk(1, 4'b0010, 0, 0, 6'd0,        1, 1, 4'b0010, 0);
        vecs[29] = mk(1, 4'b0000, 1, 0, 6'd0,        1, 1, 4'b0000, 0);
        vecs[30] = mk(1, 4'b0000, 1, 0, 6'd0,        0, 0, 4'b0000, 0);
        vecs[31] = mk(1, 4'b0000, 1, 0, 6'd0,        0, 0, 4'b0000, 0);
        vecs[32] = mk(1, 4'b0100, 0, 1, 6'd2,        0, 0, 4'b0100, 0);
        vecs[33] = mk(1, 4'b0000, 0, 0, 6'd0,        1, 2, 4'b0000, 0);
        vecs[34] = mk(1, 4'b0100, 0, 1, 6'd2,        1, 2, 4'b0100, 0);
        vecs[35] = mk(1, 4'b0000, 0, 0, 6'd0,        1, 2, 4'b0100, 0);
        vecs[36] = mk(1, 4'b0100, 1, 1, 6'd2,        1, 2, 4'b0100, 0);
        vecs[37] = mk(1, 4'b0100, 1, 0, 6'd0,        1, 2, 4'b0000, 0);
        vecs[38] = mk(1, 4'b0000, 1, 0, 6'd0,        0, 0, 4'b0000, 0);
        vecs[39] = mk(1, 4'b0000, 1, 0, 6'd0,        0, 0, 4'b0000, 0);

        step();
        for (int i = 0; i < NV; i++) begin
            v      = vecs[i];
            rst_n  = v.rst;
            sw     = v.sw;
            ready  = v.rdy;
            rep_en = 1'b0;
            for (int p = 0; p < int'(v.npush); p++) push(v.pids[p*2 +: 2], 1'b0);
            step();
            check($sformatf("vec%0d_valid", i), valid, v.e_valid);
            if (v.e_valid) begin
                check($sformatf("vec%0d_id", i), id, v.e_id);
                check($sformatf("vec%0d_rep", i), rep, 1'b0);
            end
            check($sformatf("vec%0d_pend", i), pending, v.e_pend);
            check($sformatf("vec%0d_ovf", i), ovf, v.e_ovf);
        end

        // Auto-repeat: press, first repeat 8 cycles after the rise, then every 4 cycles.
        rep_en = 1'b1;
        ready  = 1'b1;
        push(2'd2, 1'b0);
        push(2'd2, 1'b1);
        push(2'd2, 1'b1);
        push(2'd2, 1'b1);
        for (int c = 0; c < 26; c++) begin
            sw = (c < 20) ? 4'b0100 : 4'b0000;
            step();
            check($sformatf("rpt_on_valid_c%0d", c), valid,
                  (c == 1 || c == 9 || c == 13 || c == 17));
        end
        rep_en = 1'b0;
        push(2'd2, 1'b0);
        for (int c = 0; c < 26; c++) begin
            sw = (c < 20) ? 4'b0100 : 4'b0000;
            step();
            check($sformatf("rpt_off_valid_c%0d", c), valid, (c == 1));
        end

        // Reset mid-flight with one event stalled and two queued; switch 1 held through it.
        ready = 1'b0;
        sw    = 4'b0001;
        step();
        step();
        sw = 4'b1011;
        step();
        check("rst_pre_valid", valid, 1'b1);
        check("rst_pre_pend", pending, 4'b1010);
        rst_n = 1'b0;
        sw    = 4'b0010;
        #1;
        check("rst_async_outputs", {valid, id, rep, pending, ovf}, 9'd0);
        step();
        step();
        check("rst_held_outputs", {valid, id, rep, pending, ovf}, 9'd0);
        rst_n = 1'b1;
        ready = 1'b1;
        push(2'd1, 1'b0);
        for (int c = 0; c < 6; c++) step();
        sw = 4'b0000;
        for (int c = 0; c < 4; c++) step();

        check("sb_drained", sb_q.size(), 0);
        check("ovf_total", ovf_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
